// File: rtl/ptp_offset_adj.sv
// Slave-side PTP servo stage: gathers t1..t4 for one sync round, derives offset
// and mean path delay, and steps the local {ms, tick} timer by the offset.
module ptp_offset_adj #(
  parameter int W_TS         = 48,
  parameter int TICKS_PER_MS = 125000,
  parameter int MAX_ADJ      = 65535,
  parameter int TIMEOUT      = 1250000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ts_2_record,
  input  logic            ts_1_valid,
  input  logic [W_TS-1:0] ts_1,
  input  logic            ts_3_record,
  input  logic            ts_4_valid,
  input  logic [W_TS-1:0] ts_4,
  output logic [W_TS-1:0] timer,
  output logic            result_valid,
  output logic [W_TS:0]   offset,
  output logic [W_TS:0]   path_delay,
  output logic            sync_err,
  output logic [31:0]     round_cnt
);

  localparam int W_TICK = 17;
  localparam int W_MS   = W_TS - W_TICK;
  localparam int W_L    = W_TS + 1;
  localparam int W_X    = W_TS + 2;
  localparam logic signed [W_L-1:0] ADJ_HI = W_L'(MAX_ADJ);
  localparam logic signed [W_L-1:0] ADJ_LO = W_L'(-MAX_ADJ);

  typedef enum logic [1:0] {S_COLLECT, S_LIN, S_CALC, S_APPLY} state_t;

  state_t                 r_state, w_state_n;
  logic [W_MS-1:0]        r_ms, w_ms_n;
  logic [W_TICK-1:0]      r_tick, w_tick_n;
  logic [W_TS-1:0]        r_t1, r_t2, r_t3, r_t4;
  logic [3:0]             r_mask, w_mask_n;
  logic [31:0]            r_cnt, w_cnt_n;
  logic                   w_cap1, w_cap2, w_cap3, w_cap4, w_timeout;
  logic [W_L-1:0]         r_l1, r_l2, r_l3, r_l4;
  logic signed [W_L-1:0]  r_offset, r_path;
  logic signed [W_L-1:0]  w_a, w_b, w_off_n, w_path_n;
  logic signed [W_X-1:0]  w_diff, w_sum, w_tick_adj;
  logic                   r_big;
  logic [31:0]            r_round;

  function automatic logic [W_L-1:0] f_lin(input logic [W_TS-1:0] ts);
    return W_L'(ts[W_TS-1:W_TICK]) * W_L'(TICKS_PER_MS) + W_L'(ts[W_TICK-1:0]);
  endfunction

  assign timer      = {r_ms, r_tick};
  assign offset     = r_offset;
  assign path_delay = r_path;
  assign round_cnt  = r_round;

  // Mask bit i-1 tracks capture ti; t2 restarts the round and arms the timeout.
  always_comb begin
    w_state_n    = r_state;
    w_mask_n     = r_mask;
    w_cnt_n      = r_cnt;
    w_cap1       = 1'b0;
    w_cap2       = 1'b0;
    w_cap3       = 1'b0;
    w_cap4       = 1'b0;
    w_timeout    = 1'b0;
    result_valid = 1'b0;
    sync_err     = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (ts_2_record) begin
          w_cap1   = ts_1_valid;
          w_cap2   = 1'b1;
          w_cap3   = ts_3_record;
          w_cap4   = ts_4_valid;
          w_mask_n = {ts_4_valid, ts_3_record, 1'b1, ts_1_valid};
          w_cnt_n  = '0;
        end else if (r_mask[1]) begin
          if (r_cnt == 32'(TIMEOUT)) begin
            w_timeout = 1'b1;
            w_mask_n  = '0;
            w_cnt_n   = '0;
          end else begin
            w_cap1   = ts_1_valid;
            w_cap3   = ts_3_record;
            w_cap4   = ts_4_valid;
            w_mask_n = r_mask | {ts_4_valid, ts_3_record, 1'b0, ts_1_valid};
            w_cnt_n  = r_cnt + 32'd1;
          end
        end
        sync_err = w_timeout;
        if (w_mask_n == 4'b1111) w_state_n = S_LIN;
      end
      S_LIN:  w_state_n = S_CALC;
      S_CALC: w_state_n = S_APPLY;
      S_APPLY: begin
        result_valid = 1'b1;
        sync_err     = r_big;
        w_mask_n     = '0;
        w_state_n    = S_COLLECT;
      end
      default: w_state_n = S_COLLECT;
    endcase
  end

  always_comb begin
    w_a      = r_l2 - r_l1;
    w_b      = r_l4 - r_l3;
    w_diff   = W_X'(w_a) - W_X'(w_b);
    w_sum    = W_X'(w_a) + W_X'(w_b);
    w_off_n  = W_L'(w_diff >>> 1);
    w_path_n = W_L'(w_sum >>> 1);
  end

  // Offset step assumes MAX_ADJ < TICKS_PER_MS, so one borrow/carry suffices.
  always_comb begin
    w_tick_adj = W_X'($signed({1'b0, r_tick})) + W_X'(1) - W_X'(r_offset);
    w_ms_n     = r_ms;
    w_tick_n   = r_tick;
    if (r_state == S_APPLY && !r_big) begin
      if (w_tick_adj[W_X-1]) begin
        w_tick_n = W_TICK'(w_tick_adj + W_X'(TICKS_PER_MS));
        w_ms_n   = r_ms - W_MS'(1);
      end else if (w_tick_adj >= W_X'(TICKS_PER_MS)) begin
        w_tick_n = W_TICK'(w_tick_adj - W_X'(TICKS_PER_MS));
        w_ms_n   = r_ms + W_MS'(1);
      end else begin
        w_tick_n = W_TICK'(w_tick_adj);
      end
    end else if (r_tick == W_TICK'(TICKS_PER_MS - 1)) begin
      w_tick_n = '0;
      w_ms_n   = r_ms + W_MS'(1);
    end else begin
      w_tick_n = r_tick + W_TICK'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_COLLECT;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_ms    <= '0;
      r_tick  <= '0;
      r_round <= '0;
      r_t1    <= '0;
      r_t2    <= '0;
      r_t3    <= '0;
      r_t4    <= '0;
    end else begin
      r_state <= w_state_n;
      r_mask  <= w_mask_n;
      r_cnt   <= w_cnt_n;
      r_ms    <= w_ms_n;
      r_tick  <= w_tick_n;
      if (w_cap1) r_t1 <= ts_1;
      if (w_cap2) r_t2 <= timer;
      if (w_cap3) r_t3 <= timer;
      if (w_cap4) r_t4 <= ts_4;
      if (r_state == S_APPLY && !r_big) r_round <= r_round + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_l1     <= '0;
      r_l2     <= '0;
      r_l3     <= '0;
      r_l4     <= '0;
      r_offset <= '0;
      r_path   <= '0;
      r_big    <= 1'b0;
    end else begin
      if (r_state == S_LIN) begin
        r_l1 <= f_lin(r_t1);
        r_l2 <= f_lin(r_t2);
        r_l3 <= f_lin(r_t3);
        r_l4 <= f_lin(r_t4);
      end
      if (r_state == S_CALC) begin
        r_offset <= w_off_n;
        r_path   <= w_path_n;
        r_big    <= (w_off_n > ADJ_HI) || (w_off_n < ADJ_LO);
      end
    end
  end

endmodule

// File: tb/tb_ptp_offset_adj.sv
// Bench for ptp_offset_adj: a linear-time model of the timer plus a queue of
// expected result/error events, checked by an independent monitor.
module tb_ptp_offset_adj;

  localparam int     TPM  = 1000;
  localparam int     MAXA = 400;
  localparam int     TMO  = 3000;
  localparam longint MODV = longint'(TPM) * 64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic        ts_2_record, ts_1_valid, ts_3_record, ts_4_valid;
  logic [47:0] ts_1, ts_4, timer;
  logic        result_valid, sync_err;
  logic [48:0] offset, path_delay;
  logic [31:0] round_cnt;

  ptp_offset_adj #(
    .W_TS(48), .TICKS_PER_MS(TPM), .MAX_ADJ(MAXA), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .ts_2_record(ts_2_record), .ts_1_valid(ts_1_valid), .ts_1(ts_1),
    .ts_3_record(ts_3_record), .ts_4_valid(ts_4_valid), .ts_4(ts_4),
    .timer(timer), .result_valid(result_valid), .offset(offset),
    .path_delay(path_delay), .sync_err(sync_err), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else if (n_total - n_pass <= 25)
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_bound(input string nm);
    n_total++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Reference model: timer as a single linear tick count modulo 2^31 ms.
  longint lin, rc_m, adj_cyc, adj_off;
  bit     adj_en;

  function automatic longint wrapm(input longint v);
    return ((v % MODV) + MODV) % MODV;
  endfunction

  function automatic logic [47:0] to_ts(input longint v);
    longint ms, tk;
    ms = v / TPM;
    tk = v % TPM;
    return {ms[30:0], tk[16:0]};
  endfunction

  function automatic longint sx49(input logic [48:0] v);
    return longint'($signed(v));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lin  <= 0;
      rc_m <= 0;
    end else if (adj_en && cyc == adj_cyc) begin
      lin  <= wrapm(lin + 1 - adj_off);
      rc_m <= rc_m + 1;
    end else begin
      lin <= wrapm(lin + 1);
    end
  end

  typedef struct {
    longint cyc;
    bit     rv;
    bit     se;
    longint off;
    longint path;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rst_timer", longint'(timer), 0);
      chk("rst_offset", sx49(offset), 0);
      chk("rst_path", sx49(path_delay), 0);
      chk("rst_result_valid", longint'(result_valid), 0);
      chk("rst_sync_err", longint'(sync_err), 0);
      chk("rst_round_cnt", longint'(round_cnt), 0);
    end else begin
      chk("timer", longint'(timer), longint'(to_ts(lin)));
      chk("round_cnt", longint'(round_cnt), rc_m);
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("result_valid", longint'(result_valid), longint'(e.rv));
        chk("sync_err", longint'(sync_err), longint'(e.se));
        if (e.rv) begin
          chk("offset", sx49(offset), e.off);
          chk("path_delay", sx49(path_delay), e.path);
        end
      end else if (result_valid || sync_err) begin
        chk("spurious_event", longint'({result_valid, sync_err}), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_tick(input int t);
    int k;
    k = 0;
    while (lin % TPM != t && k < 3 * TPM) begin
      step();
      k++;
    end
    if (k >= 3 * TPM) fail_bound("wait_tick");
  endtask

  task automatic pulse_t2(output longint l2);
    l2 = lin;
    ts_2_record = 1'b1;
    step();
    ts_2_record = 1'b0;
  endtask

  task automatic pulse_t3(output longint l3);
    l3 = lin;
    ts_3_record = 1'b1;
    step();
    ts_3_record = 1'b0;
  endtask

  task automatic pulse_t1(input longint l1);
    ts_1 = to_ts(l1);
    ts_1_valid = 1'b1;
    step();
    ts_1_valid = 1'b0;
  endtask

  task automatic pulse_t4(input longint l4);
    ts_4 = to_ts(l4);
    ts_4_valid = 1'b1;
    step();
    ts_4_valid = 1'b0;
  endtask

  // Called just before the completing capture; the result appears 3 cycles on.
  task automatic pre_last(input int end_tick, input longint a, input longint b);
    longint d, off;
    exp_t   e;
    bit     big;
    if (end_tick >= 0) wait_tick((end_tick - 3 + TPM) % TPM);
    d   = a - b;
    off = d >>> 1;
    big = (off > MAXA) || (off < -MAXA);
    e.cyc = cyc + 3; e.rv = 1'b1; e.se = big; e.off = off; e.path = (a + b) >>> 1;
    q.push_back(e);
    adj_en  = !big;
    adj_cyc = cyc + 3;
    adj_off = off;
  endtask

  task automatic run_round(input longint a, input longint b, input int order,
                           input int end_tick, input bit poke_lin, input bit rst_calc);
    longint l2, l3;
    int k;
    k = 0;
    while (lin < 4000 && k < 10000) begin
      step();
      k++;
    end
    pulse_t2(l2);
    settle($urandom_range(0, 5));
    case (order)
      0: begin
        pulse_t1(l2 - a); settle($urandom_range(0, 6));
        pulse_t3(l3);     settle($urandom_range(0, 6));
        pre_last(end_tick, a, b); pulse_t4(l3 + b);
      end
      1: begin
        pulse_t3(l3);     settle($urandom_range(0, 6));
        pulse_t1(l2 - a); settle($urandom_range(0, 6));
        pre_last(end_tick, a, b); pulse_t4(l3 + b);
      end
      default: begin
        pulse_t3(l3);     settle($urandom_range(0, 6));
        pulse_t4(l3 + b); settle($urandom_range(0, 6));
        pre_last(end_tick, a, b); pulse_t1(l2 - a);
      end
    endcase
    if (poke_lin) begin
      ts_2_record = 1'b1;
      step();
      ts_2_record = 1'b0;
      settle(6);
      pulse_t1(lin - 10);
      pulse_t3(l3);
      pulse_t4(l3 + 20);
      settle(10);
    end else if (rst_calc) begin
      step();
      reset = 1'b0;
      q.delete();
      adj_en = 1'b0;
      settle(3);
      reset = 1'b1;
      settle(3);
    end else begin
      settle(6);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint l2, l3, n, a, b;
    int     off_t, order, et;
    exp_t   e;
    reset = 1'b1;
    ts_2_record = 1'b0; ts_1_valid = 1'b0; ts_3_record = 1'b0; ts_4_valid = 1'b0;
    ts_1 = '0; ts_4 = '0;
    adj_en = 1'b0; adj_cyc = 0; adj_off = 0;
    #1 reset = 1'b0;
    settle(4);
    reset = 1'b1;
    settle(2100);

    run_round(500, 300, 0, 200, 0, 0);
    run_round(300, 100, 1, 50, 0, 0);
    run_round(100, 300, 2, TPM - 50, 0, 0);
    run_round(1200, 200, 0, -1, 0, 0);
    run_round(900, 100, 0, 5, 0, 0);
    run_round(100, 900, 1, TPM - 5, 0, 0);
    run_round(902, 100, 2, -1, 0, 0);
    run_round(300, 501, 0, -1, 0, 0);
    run_round(-50, 250, 1, -1, 0, 0);
    run_round(700, 500, 0, -1, 1, 0);

    n = cyc;
    pulse_t2(l2);
    e.cyc = n + 1 + TMO; e.rv = 1'b0; e.se = 1'b1; e.off = 0; e.path = 0;
    q.push_back(e);
    pulse_t1(l2 - 100);
    settle(TMO + 10);
    pulse_t4(lin);
    settle(20);

    pulse_t2(l2); settle(3);
    pulse_t1(l2 - 700); settle(4);
    pulse_t2(l2); settle(2);
    pulse_t3(l3); settle(3);
    pulse_t4(l3 + 250); settle(10);
    pre_last(-1, 600, 250);
    pulse_t1(l2 - 600);
    settle(8);

    run_round(600, 200, 0, -1, 0, 1);
    run_round(400, 200, 2, -1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      off_t = int'($urandom_range(0, 2 * (MAXA + 20))) - (MAXA + 20);
      a     = longint'($urandom_range(0, 2200)) - 200;
      b     = a - 2 * longint'(off_t) - longint'($urandom_range(0, 1));
      order = int'($urandom_range(0, 2));
      et    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, TPM - 1)) : -1;
      run_round(a, b, order, et, 0, 0);
    end

    settle(10);
    chk("queue_drained", longint'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ptp_offset_adj.md
Name: ptp_offset_adj

Overview:
- Slave-side PTP servo stage directly downstream of the PTP receive parser.
- Collects the four delay-request/response timestamps for one sync round: t1 (master Sync TX), t2 (local Sync RX, sampled here), t3 (local DelayReq TX, sampled here) and t4 (master DelayReq RX).
- Computes offset and mean path delay, then steps the local mixed-radix timer it owns.
- The timer output is the `timer` consumed by the receive and transmit stages.

Parameters:
- W_TS, 48, timestamp width: {ms[47:17], tick[16:0]}, tick 0..124999 (8 ns ticks, 125 MHz).
- TICKS_PER_MS, 125000, tick wrap value.
- MAX_ADJ, 65535, largest |offset| (ticks) applied; larger offsets raise an error and are not applied.
- TIMEOUT, 1250000, cycles allowed from t2 capture to round completion (10 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ts_2_record  in  1  pulse: Sync received, sample timer as t2
- ts_1_valid  in  1  pulse: ts_1 valid
- ts_1  in  48  master t1
- ts_3_record  in  1  pulse from TX stage: DelayReq sent, sample timer as t3
- ts_4_valid  in  1  pulse: ts_4 valid
- ts_4  in  48  master t4
- timer  out  48  local mixed-radix timer
- result_valid  out  1  one-cycle pulse: offset/path_delay updated
- offset  out  49  signed ticks, two's complement: ((t2-t1)-(t4-t3))/2
- path_delay  out  49  signed ticks: ((t2-t1)+(t4-t3))/2
- sync_err  out  1  one-cycle pulse: timeout or |offset|>MAX_ADJ
- round_cnt  out  32  completed (applied) rounds, wraps

Behaviour:
- Reset: timer=0, offset=0, path_delay=0, result_valid=0, sync_err=0, round_cnt=0, capture mask=0, state COLLECT.
- Timer, every cycle:
  - tick+1.
  - tick==124999 -> tick=0, ms+1.
  - ms wraps modulo 2^31.
- Capture: t2/t3 take the timer value in the same cycle as the record pulse (the pre-increment value seen on the output that cycle). t1/t4 latch the input when valid. Each capture sets its mask bit (m1..m4).
- FSM:
  - COLLECT:
    - ts_2_record always restarts the round: mask={t2 only}, timeout counter=0. This also applies when it arrives in the same cycle as other captures; those other captures are still taken.
    - ts_1_valid, ts_3_record and ts_4_valid before m2 is set are ignored.
    - Repeated captures overwrite.
    - Timeout counter runs while m2=1. Reaching TIMEOUT -> sync_err pulse, mask=0, stay in COLLECT.
    - Mask==4'b1111 -> LIN.
  - LIN (1 cycle): linearise each timestamp L=ms*125000+tick (49-bit unsigned).
  - CALC (1 cycle): A=L2-L1, B=L4-L3 (49-bit signed). offset=(A-B)>>>1 and path_delay=(A+B)>>>1, both arithmetic shifts (truncate toward -inf). Outputs register here.
  - APPLY (1 cycle):
    - result_valid=1.
    - If |offset|>MAX_ADJ: sync_err=1, timer increments normally, round_cnt unchanged.
    - Else: tick_n=tick+1-offset. tick_n<0 -> tick_n+=125000, ms-1. tick_n>=125000 -> tick_n-=125000, ms+1. round_cnt+1.
    - Then mask=0 -> COLLECT.
- Record pulses during LIN/CALC/APPLY are ignored; no new round starts until COLLECT.
- Latency: 3 cycles from mask-complete cycle to APPLY (result_valid high in APPLY).
- Reset asserted mid-round: all state cleared immediately; no partial result is emitted.

Test Plan:
- Free run from reset, 125000 cycles -> timer goes 0:124999 -> 1:0, no result_valid, no sync_err.
- Round with t1=0:1000, t2=0:1500, t3=0:3000, t4=0:3300 (t2/t3 via forced timer or matched sampling) -> offset=100, path_delay=400, result_valid one pulse, round_cnt=1. Timer 5:200 in APPLY -> 5:101 next cycle.
- Borrow/carry at APPLY:
  - offset=+100 at timer 5:50 -> 4:124951.
  - offset=-100 at 5:124950 -> 6:51.
- Large offset: A-B=200000 -> offset=100000 -> sync_err pulse, result_valid pulse, timer unadjusted, round_cnt unchanged.
- Timeout / restart:
  - t2 captured, no t1/t3/t4 for TIMEOUT cycles -> sync_err at cycle TIMEOUT, mask cleared; a late ts_4_valid afterwards is ignored.
  - Second ts_2_record mid-round -> t2 recaptured, prior t1 discarded.
- Reset pulsed while in CALC -> outputs zero, no result_valid; a subsequent full round completes normally.
